// File: rtl/tdc_readout_uart.sv
// rtl/tdc_readout_uart.sv - TDC time word FIFO and 8N1 UART framer
// Optional feature macro: TDC_READOUT_CHECKSUM_EN (appends an XOR checksum byte)
module tdc_readout_uart #(
  parameter int CLK_DIV = 16,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               time_valid,
  input  logic [31:0]        time_data,
  output logic               uart_tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [7:0]         overflow_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(CLK_DIV);
  localparam logic [TW-1:0]    BIT_LAST   = TW'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] LEVEL_ONE  = (FIFO_AW + 1)'(1);
`ifdef TDC_READOUT_CHECKSUM_EN
  localparam logic [2:0] BYTE_LAST = 3'd5;
`else
  localparam logic [2:0] BYTE_LAST = 3'd4;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t               state_q;
  logic [31:0]          mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q;
  logic [FIFO_AW-1:0]   rd_ptr_q;
  logic [FIFO_AW:0]     level_q;
  logic [FIFO_AW:0]     level_d;
  logic [7:0]           ovf_q;
  logic [7:0]           ovf_d;
  logic [TW-1:0]        timer_q;
  logic [2:0]           bit_q;
  logic [2:0]           idx_q;
  logic [31:0]          word_q;
  logic [7:0]           byte_q;
  logic                 tx_q;
  logic                 busy_q;

  logic full;
  logic push;
  logic pop;

  // Fullness is taken from the registered level, so a same-cycle pop never rescues a strobe.
  assign full = (level_q == LEVEL_FULL);
  assign push = time_valid && !full;
  assign pop  = (state_q == S_IDLE) && (level_q != '0);

  // Byte sequence of a frame: sync, data MSB first, then optional checksum.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [31:0] w);
    logic [7:0] b;
    case (idx)
      3'd1:    b = w[31:24];
      3'd2:    b = w[23:16];
      3'd3:    b = w[15:8];
      3'd4:    b = w[7:0];
`ifdef TDC_READOUT_CHECKSUM_EN
      3'd5:    b = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
`endif
      default: b = 8'hA5;
    endcase
    return b;
  endfunction

  // Next level and saturating drop counter.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q;
    if (time_valid && full && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= time_data;
    end
  end

  // FIFO pointers, level and overflow counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // UART framer FSM; line level and busy are registered alongside each transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (pop) begin
            word_q  <= mem_q[rd_ptr_q];
            idx_q   <= 3'd0;
            byte_q  <= 8'hA5;
            timer_q <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (timer_q == BIT_LAST) begin
            timer_q <= '0;
            bit_q   <= 3'd0;
            tx_q    <= byte_q[0];
            state_q <= S_DATA;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_DATA: begin
          if (timer_q == BIT_LAST) begin
            timer_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              // Shift so the next bit to send is always at position 1 of the old value.
              bit_q  <= bit_q + 3'd1;
              byte_q <= byte_q >> 1;
              tx_q   <= byte_q[1];
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_STOP: begin
          if (timer_q == BIT_LAST) begin
            timer_q <= '0;
            if (idx_q == BYTE_LAST) begin
              busy_q  <= 1'b0;
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              idx_q   <= idx_q + 3'd1;
              byte_q  <= frame_byte(idx_q + 3'd1, word_q);
              tx_q    <= 1'b0;
              state_q <= S_START;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign uart_tx      = tx_q;
  assign busy         = busy_q;
  assign fifo_level   = level_q;
  assign overflow_cnt = ovf_q;

endmodule
